fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Sequential front-end controller that owns the architectural PC and drives instruction fetch for the single-issue core. Issues one outstanding request at a time to instruction memory, buffers the returned word for decode, advances the PC by 2, and applies branch redirects and halt from the PC/branch-resolution logic. Sits between instruction memory and decode; `pc_control` supplies `br_taken`/`br_target`, decode supplies `hlt`.

## Interface
- `RESET_PC`, 16'h0000, PC loaded on reset.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  16  fetch byte address; bit 0 always 0.
- `imem_gnt`  in  1  memory accepted request this cycle.
- `imem_rvalid`  in  1  read data valid; exactly one per granted request, ≥1 cycle after grant.
- `imem_rdata`  in  16  instruction word.
- `if_valid`  out  1  buffered instruction valid to decode.
- `if_instr`  out  16  buffered instruction.
- `if_pc`  out  16  address of `if_instr`.
- `if_ready`  in  1  decode consumes when `if_valid & if_ready`.
- `br_taken`  in  1  redirect request (single-cycle pulse).
- `br_target`  in  16  redirect address; bit 0 ignored (forced 0).
- `hlt`  in  1  decode accepted a halt instruction this cycle.
- `halted`  out  1  core halted; sticky until reset.

## Operation
- All outputs registered or decoded from registered state only.
- States: IDLE, REQ, WAIT, DRAIN, HALT.
- IDLE: reset state; next edge → REQ.
- REQ: `imem_req=1`, `imem_addr=pc`. On `imem_gnt` → WAIT.
- WAIT: on `imem_rvalid`: load buffer (`if_instr=imem_rdata`, `if_pc=pc`, `if_valid=1`), `pc <= pc+2`. Next state REQ if buffer is free after this cycle (empty, or consumed this cycle), else stay in WAIT with no request outstanding until consume, then REQ.
- Buffer holds one word; `if_valid` clears on consume unless refilled same edge.
- Redirect (`br_taken`), any state except HALT: `pc <= {br_target[15:1],1'b0}`, `if_valid <= 0`. If a request is outstanding (WAIT before rvalid, or REQ with `imem_gnt` same cycle) → DRAIN; else → REQ.
- DRAIN: no request; on `imem_rvalid`, discard data → REQ. `br_taken` in DRAIN: update pc, stay in DRAIN.
- Halt (`hlt`): `if_valid <= 0`, → DRAIN-then-HALT if request outstanding, else HALT. HALT: `imem_req=0`, `halted=1`, pc and `if_pc` frozen; exits only on reset.
- `br_taken` and `hlt` same cycle: redirect wins (branch is older); halt ignored.
- `imem_rvalid` and `br_taken` same cycle: returned data discarded, redirect applied, → REQ.
- PC wraps 16'hFFFE → 16'h0000 silently; adder overflow ignored.

## Timing
- Reset (async assert): state IDLE, `pc=RESET_PC`, `imem_req=0`, `imem_addr=RESET_PC`, `if_valid=0`, `if_instr=0`, `if_pc=RESET_PC`, `halted=0`.
- First `imem_req` high in second cycle after `rst_n` deassert.
- `imem_rvalid` → `if_valid` high next cycle (1-cycle latency).
- Zero-wait memory, decode always ready: one instruction per 2 cycles.
- Redirect without outstanding request: `imem_req` with `imem_addr=br_target` the cycle after `br_taken`.
- `halted` rises the cycle after `hlt` (no outstanding request) or after the drained `imem_rvalid`.
- Reset mid-operation: immediate return to reset values; any later `imem_rvalid` for a pre-reset request is a memory protocol error (not handled).

## Structure
- Shared package `cpu_defs`: state encodings (FS_IDLE, FS_REQ, FS_WAIT, FS_DRAIN, FS_HALT), `INSTR_W=16`, `ADDR_W=16`, `PC_STEP=16'h0002`.
- PC+2 via existing `carry_lookahead` instance (mode 0, overflow unused); no new sub-module.

## Test plan
- Reset release, `imem_gnt=1`, rvalid 1 cycle after grant, `if_ready=1` → addresses 0x0000,0x0002,0x0004… one per 2 cycles; `if_pc` matches.
- `if_ready=0` for 5 cycles with buffer full → no `imem_req`, `if_instr`/`if_pc` stable; request resumes the cycle after consume.
- `br_taken`, target 0x0101, while in WAIT → rvalid data dropped, next `imem_addr=0x0100`, `if_valid` never shows the dropped word.
- `br_taken` and `hlt` same cycle, target 0x0040 → fetch continues at 0x0040, `halted=0`.
- `hlt` with request outstanding → no further `imem_req`, `halted=1` cycle after rvalid, pc frozen 100 cycles.
- PC at 0xFFFE fetched → next `imem_addr=0x0000`; async `rst_n` low mid-WAIT → all outputs at reset values immediately.

Source files
------------

// File: rtl/cpu_defs.sv
`default_nettype none
//==============================================================================
// Module  : cpu_defs
// Brief   : Shared widths, fetch-sequencer state encodings and address helper.
// Rev     : 1.0
//==============================================================================
package cpu_defs;

    localparam int INSTR_W = 16;
    localparam int ADDR_W  = 16;
    localparam int FS_W    = 3;

    localparam logic [ADDR_W-1:0] PC_STEP = 16'h0002;

    typedef logic [FS_W-1:0] fs_state_t;

    localparam logic [FS_W-1:0] FS_IDLE  = 3'd0;
    localparam logic [FS_W-1:0] FS_REQ   = 3'd1;
    localparam logic [FS_W-1:0] FS_WAIT  = 3'd2;
    localparam logic [FS_W-1:0] FS_DRAIN = 3'd3;
    localparam logic [FS_W-1:0] FS_HALT  = 3'd4;

    // Instructions are halfword aligned, so bit 0 of any fetch address is dropped.
    function automatic logic [ADDR_W-1:0] halfword_align(input logic [ADDR_W-1:0] addr);
        return addr & {{(ADDR_W-1){1'b1}}, 1'b0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/carry_lookahead.sv
`default_nettype none
//==============================================================================
// Module  : carry_lookahead
// Brief   : Adder/subtractor with 4-bit carry-lookahead groups (mode 1 = a - b).
// Rev     : 1.0
//==============================================================================
module carry_lookahead #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             mode_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             ovf_o
);

    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_g;
    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_cin;
    logic             w_cout;

    assign w_b = mode_i ? ~b_i : b_i;
    assign w_g = a_i & w_b;
    assign w_p = a_i ^ w_b;

    // Group carry-out is formed from group generate/propagate so the chain
    // between groups skips the per-bit ripple.
    always_comb begin
        logic       v_grp_c;
        logic       v_bit_c;
        logic       v_grp_g;
        logic       v_grp_p;
        w_cin   = '0;
        v_grp_c = mode_i;
        for (int grp = 0; grp < WIDTH / 4; grp++) begin
            v_bit_c = v_grp_c;
            v_grp_g = 1'b0;
            v_grp_p = 1'b1;
            for (int k = 0; k < 4; k++) begin
                w_cin[4*grp+k] = v_bit_c;
                v_bit_c        = w_g[4*grp+k] | (w_p[4*grp+k] & v_bit_c);
                v_grp_g        = w_g[4*grp+k] | (w_p[4*grp+k] & v_grp_g);
                v_grp_p        = v_grp_p & w_p[4*grp+k];
            end
            v_grp_c = v_grp_g | (v_grp_p & v_grp_c);
        end
        w_cout = v_grp_c;
    end

    assign sum_o = w_p ^ w_cin;
    assign ovf_o = w_cout ^ w_cin[WIDTH-1];

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
//==============================================================================
// Module  : fetch_sequencer
// Brief   : Owns the PC, issues one instruction fetch at a time, buffers the
//           returned word for decode and applies redirects and halt.
// Rev     : 1.0
//==============================================================================
module fetch_sequencer
    import cpu_defs::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    input  logic               if_ready,
    input  logic               br_taken,
    input  logic [ADDR_W-1:0]  br_target,
    input  logic               hlt,
    output logic               halted
);

    fs_state_t          state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  ifpc_q, ifpc_d;
    logic               out_q, out_d;     // WAIT with a granted request still in flight
    logic               hpend_q, hpend_d; // DRAIN ends in HALT rather than REQ

    logic [ADDR_W-1:0]  w_pc_inc;
    logic               w_pc_ovf_unused;
    logic               w_live;
    logic               w_consume;
    logic               w_inflight;
    logic               w_still_out;

    carry_lookahead #(
        .WIDTH (ADDR_W)
    ) u_pc_add (
        .a_i    (pc_q),
        .b_i    (PC_STEP),
        .mode_i (1'b0),
        .sum_o  (w_pc_inc),
        .ovf_o  (w_pc_ovf_unused)
    );

    assign w_live    = (state_q != FS_HALT);
    assign w_consume = valid_q & if_ready;

    always_comb begin
        w_inflight = 1'b0;
        case (state_q)
            FS_REQ:   w_inflight = imem_gnt;
            FS_WAIT:  w_inflight = out_q;
            FS_DRAIN: w_inflight = 1'b1;
            default:  w_inflight = 1'b0;
        endcase
    end

    // A request still owed a response after this edge has to be drained first.
    assign w_still_out = w_inflight & ~imem_rvalid;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q & ~if_ready;
        instr_d = instr_q;
        ifpc_d  = ifpc_q;
        out_d   = out_q;
        hpend_d = hpend_q;

        if (w_live && br_taken) begin
            pc_d    = halfword_align(br_target);
            valid_d = 1'b0;
            out_d   = 1'b0;
            hpend_d = 1'b0;
            state_d = w_still_out ? FS_DRAIN : FS_REQ;
        end else if (w_live && hlt) begin
            valid_d = 1'b0;
            out_d   = 1'b0;
            if (w_still_out) begin
                state_d = FS_DRAIN;
                hpend_d = 1'b1;
            end else begin
                state_d = FS_HALT;
                hpend_d = 1'b0;
            end
        end else begin
            case (state_q)
                FS_IDLE: begin
                    state_d = FS_REQ;
                end
                FS_REQ: begin
                    if (imem_gnt) begin
                        state_d = FS_WAIT;
                        out_d   = 1'b1;
                    end
                end
                FS_WAIT: begin
                    if (out_q) begin
                        if (imem_rvalid) begin
                            instr_d = imem_rdata;
                            ifpc_d  = pc_q;
                            valid_d = 1'b1;
                            pc_d    = w_pc_inc;
                            out_d   = 1'b0;
                            state_d = (!valid_q || if_ready) ? FS_REQ : FS_WAIT;
                        end
                    end else if (w_consume) begin
                        state_d = FS_REQ;
                    end
                end
                FS_DRAIN: begin
                    if (imem_rvalid) begin
                        state_d = hpend_q ? FS_HALT : FS_REQ;
                        hpend_d = 1'b0;
                    end
                end
                FS_HALT: begin
                    state_d = FS_HALT;
                end
                default: begin
                    state_d = FS_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FS_IDLE;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= '0;
            ifpc_q  <= RESET_PC;
            out_q   <= 1'b0;
            hpend_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            ifpc_q  <= ifpc_d;
            out_q   <= out_d;
            hpend_q <= hpend_d;
        end
    end

    assign imem_req  = (state_q == FS_REQ);
    assign imem_addr = pc_q;
    assign if_valid  = valid_q;
    assign if_instr  = instr_q;
    assign if_pc     = ifpc_q;
    assign halted    = (state_q == FS_HALT);

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
//==============================================================================
// Module  : tb_fetch_sequencer
// Brief   : Randomised bench for fetch_sequencer against a behavioural model.
// Rev     : 1.0
//==============================================================================
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [15:0] imem_rdata = 16'h0;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic        if_ready = 1'b0;
    logic        br_taken = 1'b0;
    logic [15:0] br_target = 16'h0;
    logic        hlt = 1'b0;
    logic        halted;

    always #5 clk = ~clk;

    fetch_sequencer #(.RESET_PC(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready),
        .br_taken(br_taken), .br_target(br_target), .hlt(hlt), .halted(halted)
    );

    int errors = 0;
    int checks = 0;

    // Behavioural model: fetch front end as a set of activity flags.
    logic [15:0] m_pc, m_bi, m_bpc;
    bit m_bv, m_req, m_fly, m_disc, m_hafter, m_halt, m_park, m_idle;

    // Memory responder and stimulus knobs.
    bit mem_busy;
    int mem_cnt;
    int gnt_pct = 100, ready_pct = 100, lat_max = 1;
    bit br_now, hlt_now, last_rv;
    logic [15:0] tgt_now;

    task automatic model_reset();
        m_pc = 16'h0000; m_bi = 16'h0000; m_bpc = 16'h0000;
        m_bv = 0; m_req = 0; m_fly = 0; m_disc = 0; m_hafter = 0;
        m_halt = 0; m_park = 0; m_idle = 1;
        mem_busy = 0; mem_cnt = 0; br_now = 0; hlt_now = 0; last_rv = 0;
        imem_gnt = 0; imem_rvalid = 0; if_ready = 0; br_taken = 0; hlt = 0;
    endtask

    task automatic model_edge(input bit g, input bit rv, input logic [15:0] data,
                              input bit rd, input bit br, input logic [15:0] tgt, input bit h);
        bit consume, buf_free, fly_now, still;
        if (m_halt) return;
        consume  = m_bv && rd;
        buf_free = !m_bv || rd;
        fly_now  = m_fly || (m_req && g);
        still    = fly_now && !rv;
        if (consume) m_bv = 0;
        if (br) begin
            m_pc = {tgt[15:1], 1'b0};
            m_bv = 0; m_idle = 0; m_park = 0; m_hafter = 0;
            m_fly = still; m_disc = still; m_req = !still;
        end else if (h) begin
            m_bv = 0; m_idle = 0; m_park = 0; m_req = 0;
            if (still) begin m_fly = 1; m_disc = 1; m_hafter = 1; end
            else begin m_fly = 0; m_disc = 0; m_halt = 1; end
        end else if (m_idle) begin
            m_idle = 0; m_req = 1;
        end else if (m_req && g) begin
            m_req = 0; m_fly = 1; m_disc = 0;
        end else if (m_fly && rv) begin
            m_fly = 0;
            if (m_disc) begin
                m_disc = 0;
                if (m_hafter) begin m_hafter = 0; m_halt = 1; end
                else m_req = 1;
            end else begin
                m_bv = 1; m_bi = data; m_bpc = m_pc; m_pc = m_pc + 16'd2;
                if (buf_free) m_req = 1; else m_park = 1;
            end
        end else if (m_park && consume) begin
            m_park = 0; m_req = 1;
        end
    endtask

    task automatic cycle();
        bit g, rv, rd;
        logic [15:0] data;
        g    = imem_req && ($urandom_range(99, 0) < gnt_pct);
        rv   = mem_busy && (mem_cnt == 0);
        data = 16'($urandom);
        rd   = ($urandom_range(99, 0) < ready_pct);
        imem_gnt = g; imem_rvalid = rv; imem_rdata = data; if_ready = rd;
        br_taken = br_now; br_target = tgt_now; hlt = hlt_now;
        @(posedge clk);
        model_edge(g, rv, data, rd, br_now, tgt_now, hlt_now);
        if (rv) mem_busy = 0;
        else if (mem_busy) mem_cnt--;
        if (g) begin mem_busy = 1; mem_cnt = int'($urandom_range(lat_max - 1, 0)); end
        last_rv = rv;
        br_now = 0; hlt_now = 0;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [50:0] got, exp;
        #2 rst_n = 1'b0;
        model_reset();
        #2;
        got = {imem_req, imem_addr, if_valid, if_instr, if_pc, halted};
        checks++;
        if (got !== 51'h0) begin errors++; $display("FAIL reset_values: got %h expected %h", got, 51'h0); end
        @(posedge clk);
        #2 rst_n = 1'b1;
        checks++;
        if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_idle_req: got %b expected 0", imem_req); end
        cycle();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
            errors++; $display("FAIL reset_first_req: got req=%b addr=%h expected req=1 addr=0000", imem_req, imem_addr);
        end
        got = {imem_req, imem_req ? imem_addr : 16'h0, if_valid, if_instr, if_pc, halted};
        exp = {m_req, m_req ? m_pc : 16'h0, m_bv, m_bi, m_bpc, m_halt};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL reset_model: got %h expected %h", got, exp); end
    endtask

    task automatic test_stream();
        logic [50:0] got, exp;
        logic [15:0] exp_a = 16'h0000, exp_pc = 16'h0000;
        int reqs = 0;
        gnt_pct = 100; lat_max = 1; ready_pct = 100;
        for (int i = 0; i < 20; i++) begin
            if (imem_req === 1'b1) begin
                reqs++;
                checks++;
                if (imem_addr !== exp_a) begin errors++; $display("FAIL stream_addr %0d: got %h expected %h", i, imem_addr, exp_a); end
                exp_a = exp_a + 16'd2;
            end
            if (if_valid === 1'b1) begin
                checks++;
                if (if_pc !== exp_pc) begin errors++; $display("FAIL stream_if_pc %0d: got %h expected %h", i, if_pc, exp_pc); end
                exp_pc = exp_pc + 16'd2;
            end
            cycle();
            got = {imem_req, imem_req ? imem_addr : 16'h0, if_valid, if_instr, if_pc, halted};
            exp = {m_req, m_req ? m_pc : 16'h0, m_bv, m_bi, m_bpc, m_halt};
            checks++;
            if (got !== exp) begin errors++; $display("FAIL stream_model %0d: got %h expected %h", i, got, exp); end
        end
        checks++;
        if (reqs != 10) begin errors++; $display("FAIL stream_rate: got %0d requests expected 10", reqs); end
    endtask

    task automatic test_stall();
        logic [50:0] got, exp;
        logic [15:0] s_instr, s_pc;
        int n = 0;
        gnt_pct = 100; lat_max = 1; ready_pct = 0;
        while (!m_park && n < 12) begin cycle(); n++; end
        checks++;
        if (!m_park) begin errors++; $display("FAIL stall_reach: got no parked buffer expected parked within 12 cycles"); end
        s_instr = m_bi; s_pc = m_bpc;
        for (int i = 0; i < 5; i++) begin
            cycle();
            checks++;
            if (imem_req !== 1'b0 || if_valid !== 1'b1 || if_instr !== s_instr || if_pc !== s_pc) begin
                errors++;
                $display("FAIL stall_hold %0d: got req=%b v=%b instr=%h pc=%h expected req=0 v=1 instr=%h pc=%h",
                         i, imem_req, if_valid, if_instr, if_pc, s_instr, s_pc);
            end
        end
        ready_pct = 100;
        cycle();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== s_pc + 16'd2) begin
            errors++; $display("FAIL stall_resume: got req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, s_pc + 16'd2);
        end
        got = {imem_req, imem_req ? imem_addr : 16'h0, if_valid, if_instr, if_pc, halted};
        exp = {m_req, m_req ? m_pc : 16'h0, m_bv, m_bi, m_bpc, m_halt};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL stall_model: got %h expected %h", got, exp); end
    endtask

    task automatic test_redirect(input logic [15:0] tgt, input bit with_hlt);
        logic [50:0] got, exp;
        logic [15:0] want;
        int n = 0;
        bit seen = 0, seen_v = 0;
        want = {tgt[15:1], 1'b0};
        gnt_pct = 100; lat_max = 3; ready_pct = 100;
        while (!(m_fly && !m_disc) && n < 20) begin cycle(); n++; end
        br_now = 1; tgt_now = tgt; hlt_now = with_hlt;
        cycle();
        for (int i = 0; i < 12 && !seen_v; i++) begin
            got = {imem_req, imem_req ? imem_addr : 16'h0, if_valid, if_instr, if_pc, halted};
            exp = {m_req, m_req ? m_pc : 16'h0, m_bv, m_bi, m_bpc, m_halt};
            checks++;
            if (got !== exp) begin errors++; $display("FAIL redirect_model %h %0d: got %h expected %h", tgt, i, got, exp); end
            checks++;
            if (halted !== 1'b0) begin errors++; $display("FAIL redirect_halted %h: got %b expected 0", tgt, halted); end
            if (!seen && imem_req === 1'b1) begin
                seen = 1;
                checks++;
                if (imem_addr !== want) begin errors++; $display("FAIL redirect_addr %h: got %h expected %h", tgt, imem_addr, want); end
            end
            if (if_valid === 1'b1) begin
                seen_v = 1;
                checks++;
                if (!seen || if_pc !== want) begin errors++; $display("FAIL redirect_first_word %h: got if_pc=%h expected %h", tgt, if_pc, want); end
            end
            if (!seen_v) cycle();
        end
        checks++;
        if (!seen_v) begin errors++; $display("FAIL redirect_timeout %h: got no word expected word at %h", tgt, want); end
    endtask

    task automatic test_halt();
        logic [50:0] got, exp;
        logic [15:0] s_pc;
        int n = 0;
        bit done = 0;
        gnt_pct = 100; lat_max = 3; ready_pct = 100;
        while (!(m_fly && !m_disc && mem_busy && mem_cnt >= 1) && n < 40) begin cycle(); n++; end
        hlt_now = 1;
        cycle();
        for (int i = 0; i < 10 && !done; i++) begin
            cycle();
            checks++;
            if (halted !== last_rv) begin errors++; $display("FAIL halt_timing %0d: got halted=%b expected %b", i, halted, last_rv); end
            done = last_rv;
        end
        checks++;
        if (!done) begin errors++; $display("FAIL halt_timeout: got no drained response expected one within 10 cycles"); end
        s_pc = if_pc;
        for (int i = 0; i < 100; i++) begin
            br_now = ($urandom_range(9, 0) == 0); tgt_now = 16'($urandom);
            hlt_now = ($urandom_range(9, 0) == 0);
            cycle();
            checks++;
            if (imem_req !== 1'b0 || halted !== 1'b1 || if_valid !== 1'b0 || if_pc !== s_pc) begin
                errors++;
                $display("FAIL halt_frozen %0d: got req=%b halted=%b v=%b pc=%h expected req=0 halted=1 v=0 pc=%h",
                         i, imem_req, halted, if_valid, if_pc, s_pc);
            end
        end
        got = {imem_req, imem_req ? imem_addr : 16'h0, if_valid, if_instr, if_pc, halted};
        exp = {m_req, m_req ? m_pc : 16'h0, m_bv, m_bi, m_bpc, m_halt};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL halt_model: got %h expected %h", got, exp); end
    endtask

    task automatic test_wrap();
        logic [15:0] want [3];
        int k = 0;
        want[0] = 16'hFFFC; want[1] = 16'hFFFE; want[2] = 16'h0000;
        do_reset();
        gnt_pct = 100; lat_max = 1; ready_pct = 100;
        br_now = 1; tgt_now = 16'hFFFD;
        cycle();
        for (int i = 0; i < 12 && k < 3; i++) begin
            if (imem_req === 1'b1) begin
                checks++;
                if (imem_addr !== want[k]) begin errors++; $display("FAIL wrap_addr %0d: got %h expected %h", k, imem_addr, want[k]); end
                k++;
            end
            cycle();
        end
        checks++;
        if (k != 3) begin errors++; $display("FAIL wrap_timeout: got %0d requests expected 3", k); end
    endtask

    task automatic test_async_reset();
        logic [50:0] got;
        int n = 0;
        gnt_pct = 100; lat_max = 3; ready_pct = 100;
        while (!(m_fly && !m_disc && mem_busy && mem_cnt >= 1) && n < 40) begin cycle(); n++; end
        #2 rst_n = 1'b0;
        #1;
        got = {imem_req, imem_addr, if_valid, if_instr, if_pc, halted};
        checks++;
        if (got !== 51'h0) begin errors++; $display("FAIL async_reset: got %h expected %h", got, 51'h0); end
        model_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
        cycle();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
            errors++; $display("FAIL async_reset_restart: got req=%b addr=%h expected req=1 addr=0000", imem_req, imem_addr);
        end
    endtask

    task automatic test_random();
        logic [50:0] got, exp;
        int hcnt = 0;
        gnt_pct = 60; lat_max = 3; ready_pct = 70;
        for (int i = 0; i < 1500; i++) begin
            br_now  = ($urandom_range(99, 0) < 4);
            tgt_now = 16'($urandom);
            hlt_now = ($urandom_range(199, 0) == 0);
            cycle();
            got = {imem_req, imem_req ? imem_addr : 16'h0, if_valid, if_instr, if_pc, halted};
            exp = {m_req, m_req ? m_pc : 16'h0, m_bv, m_bi, m_bpc, m_halt};
            checks++;
            if (got !== exp) begin errors++; $display("FAIL random_model %0d: got %h expected %h", i, got, exp); end
            hcnt = m_halt ? hcnt + 1 : 0;
            if (hcnt > 6) begin do_reset(); hcnt = 0; end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect(16'h0101, 1'b0);
        test_redirect(16'h0040, 1'b1);
        test_halt();
        test_wrap();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
